// File: rtl/i2c_sensor_target_pkg.sv
// Shared definitions for the I2C temperature-sensor target: FSM states,
// register indices and the default bus address.
package i2c_sensor_target_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_WR_PTR,
        ST_ACK_PTR,
        ST_WR_DATA,
        ST_ACK_DATA,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_WAIT_STOP
    } state_t;

    localparam logic [1:0] REG_TEMP_INT  = 2'd0;
    localparam logic [1:0] REG_TEMP_FRAC = 2'd1;
    localparam logic [1:0] REG_STATUS    = 2'd2;
    localparam logic [1:0] REG_CFG       = 2'd3;

    localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h27;

    function automatic logic is_ack_state(input state_t s);
        return (s == ST_ACK_ADDR) || (s == ST_ACK_PTR) || (s == ST_ACK_DATA);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises raw SDA/SCL pins and derives START, STOP and SCL edge pulses.
// Shared between the target and master sides of the I2C path.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sda_in,
    input  logic i_scl_in,
    output logic o_sda,
    output logic o_start,
    output logic o_stop,
    output logic o_scl_rise,
    output logic o_scl_fall
);

    logic [SYNC_STAGES-1:0] sda_sync;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic                   sda_hist;
    logic                   scl_hist;
    logic                   scl_now;

    // Idle bus level is high, so all stages reset to 1 to avoid false events.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            sda_sync <= '1;
            scl_sync <= '1;
            sda_hist <= 1'b1;
            scl_hist <= 1'b1;
        end else begin
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i_sda_in};
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i_scl_in};
            sda_hist <= sda_sync[SYNC_STAGES-1];
            scl_hist <= scl_sync[SYNC_STAGES-1];
        end
    end

    assign o_sda      = sda_sync[SYNC_STAGES-1];
    assign scl_now    = scl_sync[SYNC_STAGES-1];
    assign o_start    = scl_hist & scl_now & sda_hist & ~o_sda;
    assign o_stop     = scl_hist & scl_now & ~sda_hist & o_sda;
    assign o_scl_rise = ~scl_hist & scl_now;
    assign o_scl_fall = scl_hist & ~scl_now;

endmodule

// File: rtl/i2c_sensor_target.sv
// I2C target emulating a temperature sensor: pointer write, register writes,
// auto-incrementing reads over an open-drain SDA emulation.
module i2c_sensor_target
    import i2c_sensor_target_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = DEFAULT_TARGET_ADDR,
    parameter int         DATA_DEPTH  = 8,
    parameter logic [DATA_DEPTH-1:0] CFG_RESET = '0,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_sda_in,
    input  logic                  i_scl_in,
    output logic                  o_sda_oe,
    output logic                  o_sda_out,
    input  logic [DATA_DEPTH-1:0] i_temp_int,
    input  logic [DATA_DEPTH-1:0] i_temp_frac,
    output logic [DATA_DEPTH-1:0] o_cfg,
    output logic                  o_cfg_wr,
    output logic                  o_busy
);

    localparam logic [3:0] LAST_BIT  = 4'(DATA_DEPTH - 1);
    localparam logic [3:0] BYTE_BITS = 4'(DATA_DEPTH);

    state_t                state, state_nxt;
    logic                  sda_s, ev_start, ev_stop, scl_rise, scl_fall, bus_event;
    logic [3:0]            bit_cnt;
    logic                  ack_on, rw;
    logic [DATA_DEPTH-2:0] shift_q;
    logic [DATA_DEPTH-1:0] tx_q, cfg_q, rd_data, rx_byte;
    logic [7:0]            ptr;
    logic                  cfg_written, cfg_wr_q, busy_q, sda_oe_q, sda_oe_nxt;
    logic                  addr_match, load_byte, reg_write;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bus_sync (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_sda_in   (i_sda_in),
        .i_scl_in   (i_scl_in),
        .o_sda      (sda_s),
        .o_start    (ev_start),
        .o_stop     (ev_stop),
        .o_scl_rise (scl_rise),
        .o_scl_fall (scl_fall)
    );

    assign bus_event  = ev_start | ev_stop;
    assign rx_byte    = {shift_q, sda_s};
    assign addr_match = (rx_byte[7:1] == TARGET_ADDR);

    always_comb begin
        rd_data = cfg_q;
        case (ptr[1:0])
            REG_TEMP_INT:  rd_data = i_temp_int;
            REG_TEMP_FRAC: rd_data = i_temp_frac;
            REG_STATUS:    rd_data = {{(DATA_DEPTH-1){1'b0}}, cfg_written};
            default:       rd_data = cfg_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Bus conditions override everything; ACK states take two SCL falls.
    always_comb begin
        state_nxt = state;
        if (ev_start) begin
            state_nxt = ST_ADDR;
        end else if (ev_stop) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_ADDR:     if (scl_rise && bit_cnt == LAST_BIT)
                                 state_nxt = addr_match ? ST_ACK_ADDR : ST_IDLE;
                ST_ACK_ADDR: if (scl_fall && ack_on)
                                 state_nxt = rw ? ST_RD_BYTE : ST_WR_PTR;
                ST_WR_PTR:   if (scl_rise && bit_cnt == LAST_BIT) state_nxt = ST_ACK_PTR;
                ST_ACK_PTR:  if (scl_fall && ack_on) state_nxt = ST_WR_DATA;
                ST_WR_DATA:  if (scl_rise && bit_cnt == LAST_BIT) state_nxt = ST_ACK_DATA;
                ST_ACK_DATA: if (scl_fall && ack_on) state_nxt = ST_WR_DATA;
                ST_RD_BYTE:  if (scl_fall && bit_cnt == BYTE_BITS) state_nxt = ST_RD_ACK;
                ST_RD_ACK:   if (scl_rise) state_nxt = sda_s ? ST_WAIT_STOP : ST_RD_BYTE;
                default:     state_nxt = state;
            endcase
        end
    end

    always_comb begin
        sda_oe_nxt = sda_oe_q;
        load_byte  = 1'b0;
        reg_write  = 1'b0;
        if (bus_event) begin
            sda_oe_nxt = 1'b0;
        end else begin
            case (state)
                ST_ACK_ADDR, ST_ACK_PTR, ST_ACK_DATA: begin
                    if (scl_fall) begin
                        if (!ack_on) begin
                            sda_oe_nxt = 1'b1;
                        end else if (state == ST_ACK_ADDR && rw) begin
                            load_byte  = 1'b1;
                            sda_oe_nxt = ~rd_data[DATA_DEPTH-1];
                        end else begin
                            sda_oe_nxt = 1'b0;
                        end
                    end
                end
                ST_RD_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd0) begin
                            load_byte  = 1'b1;
                            sda_oe_nxt = ~rd_data[DATA_DEPTH-1];
                        end else if (bit_cnt == BYTE_BITS) begin
                            sda_oe_nxt = 1'b0;
                        end else begin
                            sda_oe_nxt = ~tx_q[DATA_DEPTH-1];
                        end
                    end
                end
                ST_WR_DATA: begin
                    sda_oe_nxt = 1'b0;
                    reg_write  = scl_rise && (bit_cnt == LAST_BIT);
                end
                default: sda_oe_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            sda_oe_q    <= 1'b0;
            bit_cnt     <= 4'd0;
            ack_on      <= 1'b0;
            rw          <= 1'b0;
            shift_q     <= '0;
            tx_q        <= '0;
            ptr         <= 8'd0;
            cfg_q       <= CFG_RESET;
            cfg_written <= 1'b0;
            cfg_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sda_oe_q <= sda_oe_nxt;
            cfg_wr_q <= 1'b0;

            if (state_nxt == ST_IDLE)
                busy_q <= 1'b0;
            else if (state == ST_ADDR && state_nxt == ST_ACK_ADDR)
                busy_q <= 1'b1;

            // A byte load already puts bit 7 on the wire, so the count starts at 1.
            if (load_byte) begin
                tx_q    <= rd_data << 1;
                bit_cnt <= 4'd1;
            end else if (ev_start || state_nxt != state) begin
                bit_cnt <= 4'd0;
                ack_on  <= 1'b0;
            end else if (scl_rise && (state == ST_ADDR || state == ST_WR_PTR || state == ST_WR_DATA)) begin
                shift_q <= rx_byte[DATA_DEPTH-2:0];
                bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && state == ST_RD_BYTE) begin
                tx_q    <= tx_q << 1;
                bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && is_ack_state(state)) begin
                ack_on  <= 1'b1;
            end

            if (!bus_event && scl_rise && bit_cnt == LAST_BIT && state == ST_ADDR)
                rw <= sda_s;
            if (!bus_event && scl_rise && bit_cnt == LAST_BIT && state == ST_WR_PTR)
                ptr <= rx_byte;
            if (reg_write) begin
                if (ptr[1:0] == REG_CFG) begin
                    cfg_q       <= rx_byte;
                    cfg_written <= 1'b1;
                    cfg_wr_q    <= 1'b1;
                end
                ptr <= ptr + 8'd1;
            end
            if (!bus_event && scl_rise && state == ST_RD_ACK)
                ptr <= ptr + 8'd1;
        end
    end

    assign o_sda_oe  = sda_oe_q;
    assign o_sda_out = 1'b0;
    assign o_cfg     = cfg_q;
    assign o_cfg_wr  = cfg_wr_q;
    assign o_busy    = busy_q;

endmodule

// File: doc/i2c_sensor_target.md
Name: i2c_sensor_target

Overview:
- I2C target (responder) emulating the temperature sensor polled by the I2C master FSM/FIFO path.
- Decodes START/STOP, matches a 7-bit address, and accepts a register-pointer write and optional data writes.
- Returns register bytes on reads, with pointer auto-increment.
- Sits on the same sda/scl split-line interface as the master. Used as the on-board loopback target and as the bench partner for the master chain.

Parameters:
- TARGET_ADDR, 7'h27, 7-bit address. Matches 8'h4E write and 8'h4F read.
- DATA_DEPTH, 8, register/byte width.
- CFG_RESET, 8'h00, reset value of config register.
- SYNC_STAGES, 2, input synchronizer depth (≥2).

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-low reset (0 = reset).
- i_sda_in  in  1  SDA pin level.
- i_scl_in  in  1  SCL pin level.
- o_sda_oe  out  1  1 = drive SDA low (open-drain emulation).
- o_sda_out  out  1  constant 0.
- i_temp_int  in  8  temperature integer byte (reg 0).
- i_temp_frac  in  8  temperature fraction byte (reg 1).
- o_cfg  out  8  config register (reg 3).
- o_cfg_wr  out  1  one-cycle pulse when reg 3 is written.
- o_busy  out  1  high from addressed START until STOP/NACK-release.

Behaviour:
- Reset (i_rst=0 at clk edge):
  - State IDLE; o_sda_oe=0; o_sda_out=0; o_cfg=CFG_RESET; o_cfg_wr=0; o_busy=0.
  - Pointer=0; synchronizers loaded with 1.
  - Reset mid-transfer releases SDA on the next edge.
- Inputs pass through SYNC_STAGES flops plus one history flop. Events are detected SYNC_STAGES+1 cycles after a pin change.
- Event detection:
  - START = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
  - SCL_RISE and SCL_FALL are edges of synced SCL.
- Register map (2-bit index, pointer bits [1:0]):
  - 0 = i_temp_int (RO).
  - 1 = i_temp_frac (RO).
  - 2 = status RO, {7'b0, cfg_written_since_reset}.
  - 3 = config RW.
  - Writes to 0..2 are ACKed and discarded.
  - Pointer is stored 8-bit; upper bits are ignored for decode.
- Bit timing:
  - Sample SDA on SCL_RISE, MSB first.
  - Change o_sda_oe only on SCL_FALL.
- States:
  - IDLE: START -> ADDR (bit count=0).
  - ADDR: shift 8 bits. On the 8th SCL_RISE:
    - match -> ACK_ADDR, with R/W latched.
    - no match -> IDLE (SDA never driven).
  - ACK_ADDR: on next SCL_FALL set oe=1; on the following SCL_FALL:
    - R/W=0 -> WR_PTR, releasing oe.
    - R/W=1 -> RD_BYTE, with oe=~reg[ptr][7].
  - WR_PTR: 8 bits -> pointer; then ACK_PTR (same ACK timing) -> WR_DATA.
  - WR_DATA: 8 bits. Write reg[ptr] at the 8th SCL_RISE (o_cfg_wr pulses if ptr=3), then ptr++. ACK_DATA -> WR_DATA.
  - RD_BYTE: drive ~bit on each SCL_FALL (oe=1 for a 0 bit). After the 8th bit's SCL_FALL, release SDA -> RD_ACK.
  - RD_ACK: sample master ACK on SCL_RISE; ptr++ either way.
    - ACK (SDA=0) -> RD_BYTE, loading the next byte on the next SCL_FALL.
    - NACK -> WAIT_STOP (oe=0).
  - WAIT_STOP: ignore bits until START/STOP.
- START in any state -> ADDR (repeated start); the pointer is retained. STOP in any state -> IDLE with oe=0.
- The read byte is captured from reg[ptr] at the SCL_FALL that begins it. i_temp_* may change at any time.
- Pointer wraps 8'hFF->8'h00.
- The block never drives SCL (no clock stretching). Requires i_clk ≥ 8× SCL frequency.
- o_busy=1 from address match until IDLE.

Decomposition:
- Shared package: state encodings; register indices (REG_TEMP_INT=0, REG_TEMP_FRAC=1, REG_STATUS=2, REG_CFG=3); default TARGET_ADDR.
- Sub-module: i2c_bus_sync. Covers synchronizers, history flops, and the START/STOP/SCL_RISE/SCL_FALL pulses. It is reusable by the master side.

Test Plan:
- Write address 8'h4E, pointer 8'h03, data 8'h04, STOP:
  - three ACKs;
  - o_cfg=8'h04;
  - o_cfg_wr one pulse;
  - o_busy low after STOP.
- Write 8'h4E, pointer 8'h00, repeated START, read 8'h4F, with i_temp_int=8'h19 and i_temp_frac=8'h80:
  - master ACKs byte 1 and reads 8'h19;
  - master NACKs byte 2 and reads 8'h80;
  - SDA is released after the NACK.
- Address 8'h90:
  - no ACK (SDA stays 1 on 9th clock);
  - o_busy stays 0;
  - traffic ignored until next START.
- Pointer 8'h03, then 3-byte read with ACK, ACK, NACK -> bytes cfg, temp_int, temp_frac (wrap 3->0->1).
- STOP injected after bit 4 of the data phase:
  - immediate IDLE;
  - o_sda_oe=0;
  - no register write;
  - next transaction is normal.
- Assert i_rst=0 during ACK_ADDR while oe=1:
  - oe=0 on the next clock;
  - o_cfg=CFG_RESET;
  - state IDLE.
